// File: rtl/freq_lock_pkg.sv
// freq_lock_pkg: shared types, default parameters and counter sizing for the frequency-lock controller.
package freq_lock_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, LOCKED} state_e;
  typedef enum logic [1:0] {NONE, UP, DOWN} dir_e;
  localparam int CODE_W_DEF = 8;
  localparam int CODE_INIT_DEF = 128;
  localparam int STEP_INIT_DEF = 16;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int LOCK_CYC_DEF = 16;
  localparam int UNLOCK_CNT_DEF = 3;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/freq_lock_ctrl_if.sv
// freq_lock_ctrl_if: comparator-side requests in, DCO-side control word and status out.
interface freq_lock_ctrl_if #(parameter int CODE_W = 8);
  logic enable;
  logic freqInc;
  logic freqDec;
  logic cmpEnable;
  logic [CODE_W-1:0] dcoCode;
  logic locked;
  logic codeSat;
  modport master(output enable, freqInc, freqDec, input cmpEnable, dcoCode, locked, codeSat);
  modport slave(input enable, freqInc, freqDec, output cmpEnable, dcoCode, locked, codeSat);
endinterface

// File: rtl/freq_lock_step_unit.sv
// freq_lock_step_unit: halves the step on a direction reversal and applies a saturating code correction.
module freq_lock_step_unit
  import freq_lock_pkg::*;
#(
  parameter int CODE_W = 8
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [CODE_W-1:0] step_i,
  input  dir_e              last_i,
  input  logic              up_i,
  output logic [CODE_W-1:0] code_o,
  output logic [CODE_W-1:0] step_o,
  output logic              sat_o
);
  logic rev;
  logic [CODE_W:0] sum;
  always_comb begin
    rev = up_i ? (last_i == DOWN) : (last_i == UP);
    step_o = !rev ? step_i : (|step_i[CODE_W-1:1]) ? step_i >> 1 : CODE_W'(1);
    sum = up_i ? {1'b0, code_i} + {1'b0, step_o} : {1'b0, code_i} - {1'b0, step_o};
    // the extra bit flags overflow on add and borrow on subtract
    code_o = sum[CODE_W] ? {CODE_W{up_i}} : sum[CODE_W-1:0];
    sat_o = (code_o == '0) || (&code_o);
  end
endmodule

// File: rtl/freq_lock_ctrl.sv
// freq_lock_ctrl: coarse DCO frequency acquisition with step halving, settle blanking and lock detection.
module freq_lock_ctrl
  import freq_lock_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int CODE_INIT = CODE_INIT_DEF,
  parameter int STEP_INIT = STEP_INIT_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int LOCK_CYC = LOCK_CYC_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input logic refClk,
  input logic reset,
  freq_lock_ctrl_if.slave bus
);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int QW = cnt_w(LOCK_CYC);
  localparam int MW = cnt_w(UNLOCK_CNT);
  state_e state_q, state_d;
  dir_e last_q, last_d;
  logic [CODE_W-1:0] code_q, code_d, step_q, step_d, new_code, new_step;
  logic [SW-1:0] settle_q, settle_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [MW-1:0] miss_q, miss_d;
  logic locked_q, locked_d, sat_q, sat_d, cmp_q, cmp_d, new_sat;
  logic pulse, both, quiet_end, miss_end;
  assign pulse = bus.freqInc ^ bus.freqDec;
  assign both = bus.freqInc & bus.freqDec;
  assign quiet_end = quiet_q == QW'(LOCK_CYC - 1);
  assign miss_end = miss_q == MW'(UNLOCK_CNT - 1);
  freq_lock_step_unit #(.CODE_W(CODE_W)) u_step (
    .code_i(code_q),
    .step_i(step_q),
    .last_i(last_q),
    .up_i(bus.freqInc),
    .code_o(new_code),
    .step_o(new_step),
    .sat_o(new_sat)
  );
  always_ff @(posedge refClk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (!bus.enable) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:    state_d = SETTLE;
        SETTLE:  state_d = (settle_q != '0) ? SETTLE : locked_q ? LOCKED : ACQUIRE;
        ACQUIRE: state_d = pulse ? SETTLE : (!both && !bus.freqInc && quiet_end) ? LOCKED : ACQUIRE;
        LOCKED:  state_d = (pulse && miss_end) ? ACQUIRE : LOCKED;
      endcase
  end
  always_comb begin
    code_d = code_q;
    step_d = step_q;
    last_d = last_q;
    settle_d = settle_q;
    quiet_d = quiet_q;
    miss_d = miss_q;
    locked_d = locked_q;
    sat_d = sat_q;
    if (!bus.enable) begin
      code_d = CODE_W'(CODE_INIT);
      step_d = CODE_W'(STEP_INIT);
      last_d = NONE;
      settle_d = '0;
      quiet_d = '0;
      miss_d = '0;
      locked_d = 1'b0;
      sat_d = 1'b0;
    end else
      unique case (state_q)
        IDLE:   settle_d = SW'(SETTLE_CYC - 1);
        SETTLE: settle_d = settle_q - SW'(1);
        ACQUIRE:
          if (pulse) begin
            code_d = new_code;
            step_d = new_step;
            sat_d = new_sat;
            last_d = bus.freqInc ? UP : DOWN;
            quiet_d = '0;
            settle_d = SW'(SETTLE_CYC - 1);
          end else begin
            quiet_d = (both || quiet_end) ? '0 : quiet_q + QW'(1);
            locked_d = !both && quiet_end;
          end
        LOCKED:
          if (pulse) begin
            quiet_d = '0;
            miss_d = miss_end ? '0 : miss_q + MW'(1);
            // re-acquisition restarts with the finest step and no reversal history
            locked_d = !miss_end;
            step_d = miss_end ? CODE_W'(1) : step_q;
            last_d = miss_end ? NONE : last_q;
          end else begin
            quiet_d = (both || quiet_end) ? '0 : quiet_q + QW'(1);
            miss_d = (!both && quiet_end) ? '0 : miss_q;
          end
      endcase
    cmp_d = (state_d == ACQUIRE) || (state_d == LOCKED);
  end
  always_ff @(posedge refClk or negedge reset)
    if (!reset) begin
      code_q <= CODE_W'(CODE_INIT);
      step_q <= CODE_W'(STEP_INIT);
      last_q <= NONE;
      settle_q <= '0;
      quiet_q <= '0;
      miss_q <= '0;
      locked_q <= 1'b0;
      sat_q <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      code_q <= code_d;
      step_q <= step_d;
      last_q <= last_d;
      settle_q <= settle_d;
      quiet_q <= quiet_d;
      miss_q <= miss_d;
      locked_q <= locked_d;
      sat_q <= sat_d;
      cmp_q <= cmp_d;
    end
  assign bus.cmpEnable = cmp_q;
  assign bus.dcoCode = code_q;
  assign bus.locked = locked_q;
  assign bus.codeSat = sat_q;
endmodule
